net_tx_arbiter: RTL and testbench

NET_TX_ARBITER -- requirements
Module: net_tx_arbiter

---
 rtl/ompcnet_pkg.sv | 14 +
 rtl/net_tx_arb_sel.sv | 45 ++++
 rtl/net_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_net_tx_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ompcnet_pkg.sv
// Shared requester indices and arbiter FSM state type for the network TX path.
package ompcnet_pkg;

  localparam logic [1:0] REQ_DATA   = 2'd0;
  localparam logic [1:0] REQ_APP_HS = 2'd1;
  localparam logic [1:0] REQ_NET_HS = 2'd2;
  localparam logic [1:0] REQ_NONE   = 2'd3;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_e;

endpackage

// File: rtl/net_tx_arb_sel.sv
// Winner selection for the TX arbiter: round-robin from the pointer, or strict
// priority 2 > 1 > 0 when NET_TX_ARB_HS_PRIORITY_EN is defined.
module net_tx_arb_sel
  import ompcnet_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_winner
);

`ifdef NET_TX_ARB_HS_PRIORITY_EN
  logic [1:0] w_unused_ptr;
  assign w_unused_ptr = i_ptr;

  always_comb begin
    o_winner = REQ_NONE;
    if (i_req[REQ_NET_HS]) o_winner = REQ_NET_HS;
    else if (i_req[REQ_APP_HS]) o_winner = REQ_APP_HS;
    else if (i_req[REQ_DATA]) o_winner = REQ_DATA;
  end
`else
  // Search starts one past the last granted index and wraps 2 -> 0.
  always_comb begin
    o_winner = REQ_NONE;
    case (i_ptr)
      REQ_DATA: begin
        if (i_req[REQ_APP_HS]) o_winner = REQ_APP_HS;
        else if (i_req[REQ_NET_HS]) o_winner = REQ_NET_HS;
        else if (i_req[REQ_DATA]) o_winner = REQ_DATA;
      end
      REQ_APP_HS: begin
        if (i_req[REQ_NET_HS]) o_winner = REQ_NET_HS;
        else if (i_req[REQ_DATA]) o_winner = REQ_DATA;
        else if (i_req[REQ_APP_HS]) o_winner = REQ_APP_HS;
      end
      default: begin
        if (i_req[REQ_DATA]) o_winner = REQ_DATA;
        else if (i_req[REQ_APP_HS]) o_winner = REQ_APP_HS;
        else if (i_req[REQ_NET_HS]) o_winner = REQ_NET_HS;
      end
    endcase
  end
`endif

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-granular 3:1 AXI4-Stream arbiter onto the network egress, one register stage.
// Define NET_TX_ARB_HS_PRIORITY_EN for strict priority instead of round-robin.
module net_tx_arbiter
  import ompcnet_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEST_W = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst,

  input  logic [DATA_W-1:0]   app2net_data_tx_TDATA,
  input  logic [DATA_W/8-1:0] app2net_data_tx_TKEEP,
  input  logic [DATA_W/8-1:0] app2net_data_tx_TSTRB,
  input  logic                app2net_data_tx_TLAST,
  input  logic [DEST_W-1:0]   app2net_data_tx_TDEST,
  input  logic                app2net_data_tx_TVALID,
  output logic                app2net_data_tx_TREADY,

  input  logic [DATA_W-1:0]   app2net_hs_tx_TDATA,
  input  logic [DATA_W/8-1:0] app2net_hs_tx_TKEEP,
  input  logic [DATA_W/8-1:0] app2net_hs_tx_TSTRB,
  input  logic                app2net_hs_tx_TLAST,
  input  logic [DEST_W-1:0]   app2net_hs_tx_TDEST,
  input  logic                app2net_hs_tx_TVALID,
  output logic                app2net_hs_tx_TREADY,

  input  logic [DATA_W-1:0]   net2app_hs_tx_TDATA,
  input  logic [DATA_W/8-1:0] net2app_hs_tx_TKEEP,
  input  logic [DATA_W/8-1:0] net2app_hs_tx_TSTRB,
  input  logic                net2app_hs_tx_TLAST,
  input  logic [DEST_W-1:0]   net2app_hs_tx_TDEST,
  input  logic                net2app_hs_tx_TVALID,
  output logic                net2app_hs_tx_TREADY,

  output logic [DATA_W-1:0]   network_tx_TDATA,
  output logic [DATA_W/8-1:0] network_tx_TKEEP,
  output logic [DATA_W/8-1:0] network_tx_TSTRB,
  output logic                network_tx_TLAST,
  output logic [DEST_W-1:0]   network_tx_TDEST,
  output logic                network_tx_TVALID,
  input  logic                network_tx_TREADY,

  output logic [1:0]          arb_grant,
  output logic                arb_busy
);

  localparam int unsigned KeepW = DATA_W / 8;

  // Slot 3 is a tied-off dummy so the grant can index the arrays directly.
  logic [DATA_W-1:0] w_tdata [4];
  logic [KeepW-1:0]  w_tkeep [4];
  logic [KeepW-1:0]  w_tstrb [4];
  logic [DEST_W-1:0] w_tdest [4];
  logic [3:0]        w_tvalid;
  logic [3:0]        w_tlast;
  logic [3:0]        w_tready;

  assign w_tdata[0] = app2net_data_tx_TDATA;
  assign w_tdata[1] = app2net_hs_tx_TDATA;
  assign w_tdata[2] = net2app_hs_tx_TDATA;
  assign w_tdata[3] = '0;
  assign w_tkeep[0] = app2net_data_tx_TKEEP;
  assign w_tkeep[1] = app2net_hs_tx_TKEEP;
  assign w_tkeep[2] = net2app_hs_tx_TKEEP;
  assign w_tkeep[3] = '0;
  assign w_tstrb[0] = app2net_data_tx_TSTRB;
  assign w_tstrb[1] = app2net_hs_tx_TSTRB;
  assign w_tstrb[2] = net2app_hs_tx_TSTRB;
  assign w_tstrb[3] = '0;
  assign w_tdest[0] = app2net_data_tx_TDEST;
  assign w_tdest[1] = app2net_hs_tx_TDEST;
  assign w_tdest[2] = net2app_hs_tx_TDEST;
  assign w_tdest[3] = '0;
  assign w_tvalid   = {1'b0, net2app_hs_tx_TVALID, app2net_hs_tx_TVALID, app2net_data_tx_TVALID};
  assign w_tlast    = {1'b0, net2app_hs_tx_TLAST, app2net_hs_tx_TLAST, app2net_data_tx_TLAST};

  arb_state_e        r_state, w_state_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [1:0]        w_ptr;
  logic [1:0]        w_winner;
  logic              w_out_free;
  logic              w_acc;

  logic              r_tvalid;
  logic [DATA_W-1:0] r_tdata;
  logic [KeepW-1:0]  r_tkeep;
  logic [KeepW-1:0]  r_tstrb;
  logic              r_tlast;
  logic [DEST_W-1:0] r_tdest;

  net_tx_arb_sel u_sel (
    .i_req    (w_tvalid[2:0]),
    .i_ptr    (w_ptr),
    .o_winner (w_winner)
  );

`ifdef NET_TX_ARB_HS_PRIORITY_EN
  assign w_ptr = REQ_NONE;
`else
  logic [1:0] r_last_grant;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_last_grant <= REQ_NET_HS;
    end else if (w_acc && w_tlast[r_grant]) begin
      r_last_grant <= r_grant;
    end
  end

  assign w_ptr = r_last_grant;
`endif

  assign w_out_free = !r_tvalid || network_tx_TREADY;
  // Upstream never sees a handshake while reset is asserted.
  assign w_acc      = (r_state == LOCKED) && w_tvalid[r_grant] && w_out_free && !ap_rst;

  always_comb begin
    w_tready = '0;
    if (r_state == LOCKED) begin
      w_tready[r_grant] = w_out_free && !ap_rst;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_grant <= REQ_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        if (|w_tvalid[2:0]) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_winner;
        end
      end
      LOCKED: begin
        if (w_acc && w_tlast[r_grant]) begin
          w_state_nxt = IDLE;
          w_grant_nxt = REQ_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tvalid <= 1'b0;
    end else if (w_acc) begin
      r_tvalid <= 1'b1;
    end else if (network_tx_TREADY) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_acc) begin
      r_tdata <= w_tdata[r_grant];
      r_tkeep <= w_tkeep[r_grant];
      r_tstrb <= w_tstrb[r_grant];
      r_tlast <= w_tlast[r_grant];
      r_tdest <= w_tdest[r_grant];
    end
  end

  assign app2net_data_tx_TREADY = w_tready[0];
  assign app2net_hs_tx_TREADY   = w_tready[1];
  assign net2app_hs_tx_TREADY   = w_tready[2];

  assign network_tx_TDATA  = r_tdata;
  assign network_tx_TKEEP  = r_tkeep;
  assign network_tx_TSTRB  = r_tstrb;
  assign network_tx_TLAST  = r_tlast;
  assign network_tx_TDEST  = r_tdest;
  assign network_tx_TVALID = r_tvalid;

  assign arb_grant = r_grant;
  assign arb_busy  = (r_state == LOCKED);

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Randomized bench for net_tx_arbiter: queue-based reference model plus directed scenarios.
module tb_net_tx_arbiter;

  localparam int unsigned DW  = 64;
  localparam int unsigned DSW = 8;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic [DW/8-1:0] strb;
    logic            last;
    logic [DSW-1:0]  dest;
  } beat_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [2:0] in_v = '0;
  beat_t in_b [3];
  logic net_rdy = 1'b1;
  logic [2:0] rdy;
  logic [DW-1:0] o_data;
  logic [DW/8-1:0] o_keep, o_strb;
  logic o_last, o_valid, arb_busy;
  logic [DSW-1:0] o_dest;
  logic [1:0] arb_grant;

  int n_checks = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  net_tx_arbiter #(.DATA_W(DW), .DEST_W(DSW)) dut (
    .ap_clk                 (ap_clk),
    .ap_rst                 (ap_rst),
    .app2net_data_tx_TDATA  (in_b[0].data),
    .app2net_data_tx_TKEEP  (in_b[0].keep),
    .app2net_data_tx_TSTRB  (in_b[0].strb),
    .app2net_data_tx_TLAST  (in_b[0].last),
    .app2net_data_tx_TDEST  (in_b[0].dest),
    .app2net_data_tx_TVALID (in_v[0]),
    .app2net_data_tx_TREADY (rdy[0]),
    .app2net_hs_tx_TDATA    (in_b[1].data),
    .app2net_hs_tx_TKEEP    (in_b[1].keep),
    .app2net_hs_tx_TSTRB    (in_b[1].strb),
    .app2net_hs_tx_TLAST    (in_b[1].last),
    .app2net_hs_tx_TDEST    (in_b[1].dest),
    .app2net_hs_tx_TVALID   (in_v[1]),
    .app2net_hs_tx_TREADY   (rdy[1]),
    .net2app_hs_tx_TDATA    (in_b[2].data),
    .net2app_hs_tx_TKEEP    (in_b[2].keep),
    .net2app_hs_tx_TSTRB    (in_b[2].strb),
    .net2app_hs_tx_TLAST    (in_b[2].last),
    .net2app_hs_tx_TDEST    (in_b[2].dest),
    .net2app_hs_tx_TVALID   (in_v[2]),
    .net2app_hs_tx_TREADY   (rdy[2]),
    .network_tx_TDATA       (o_data),
    .network_tx_TKEEP       (o_keep),
    .network_tx_TSTRB       (o_strb),
    .network_tx_TLAST       (o_last),
    .network_tx_TDEST       (o_dest),
    .network_tx_TVALID      (o_valid),
    .network_tx_TREADY      (net_rdy),
    .arb_grant              (arb_grant),
    .arb_busy               (arb_busy)
  );

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for traffic to drain", name);
  endtask

  function automatic int pick(logic [2:0] v, int last);
    int w;
    w = 3;
`ifdef NET_TX_ARB_HS_PRIORITY_EN
    for (int k = 0; k < 3; k++) if (v[k]) w = k;
    if (last > 3) w = 3;
`else
    for (int k = 3; k >= 1; k--) if (v[(last + k) % 3]) w = (last + k) % 3;
`endif
    return w;
  endfunction

  // Reference model: owner of the egress (3 = none) and a queue of beats in flight.
  int    m_owner = 3;
  int    m_last = 2;
  beat_t m_q[$];
  logic [2:0] m_rdy;
  beat_t ob;

  always @(negedge ap_clk) begin
    ob.data = o_data;
    ob.keep = o_keep;
    ob.strb = o_strb;
    ob.last = o_last;
    ob.dest = o_dest;
    for (int i = 0; i < 3; i++)
      m_rdy[i] = !ap_rst && (m_owner == i) && (m_q.size() == 0 || net_rdy);
    chk("arb_grant", arb_grant, m_owner);
    chk("arb_busy", arb_busy, m_owner != 3);
    chk("tready", rdy, m_rdy);
    chk("net_tvalid", o_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("net_beat", ob, m_q[0]);
    if (ap_rst) begin
      m_owner = 3;
      m_last = 2;
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && net_rdy) void'(m_q.pop_front());
      if (m_owner == 3) begin
        m_owner = pick(in_v, m_last);
      end else if (in_v[m_owner] && m_rdy[m_owner]) begin
        m_q.push_back(in_b[m_owner]);
        if (in_b[m_owner].last) begin
          m_last = m_owner;
          m_owner = 3;
        end
      end
    end
  end

  // Traffic sources
  int src_npk[3], src_len[3], src_fix[3], src_idx[3], src_seq[3], src_pv[3], src_hold[3];
  int nr_pct = 100;
  int tot_beats = 0;
  int n_in = 0;
  int n_out = 0;
  bit hold_trig = 0;
  logic [2:0] acc;
  bit stall_prev = 0;
  beat_t prev_ob;

  function automatic beat_t mk_beat(int i);
    beat_t b;
    b.data = {$urandom(), 16'(i), 16'(src_seq[i])};
    b.keep = 8'($urandom());
    b.strb = 8'($urandom());
    b.dest = 8'($urandom());
    b.last = (src_idx[i] == src_len[i] - 1);
    return b;
  endfunction

  task automatic new_len(int i);
    src_len[i] = (src_fix[i] != 0) ? src_fix[i] : int'($urandom_range(5, 1));
    tot_beats += src_len[i];
  endtask

  task automatic start_src(int i, int npk, int len, int pv);
    src_npk[i] = npk;
    src_fix[i] = len;
    src_pv[i]  = pv;
    src_idx[i] = 0;
    src_hold[i] = 0;
    new_len(i);
  endtask

  task automatic clear_src();
    for (int i = 0; i < 3; i++) begin
      src_npk[i] = 0;
      src_idx[i] = 0;
      src_hold[i] = 0;
    end
    in_v = '0;
  endtask

  function automatic bit done();
    return (src_npk[0] == 0) && (src_npk[1] == 0) && (src_npk[2] == 0) && (in_v == 3'b000)
        && !o_valid && !arb_busy;
  endfunction

  task automatic sample();
    beat_t cur;
    @(negedge ap_clk);
    cur.data = o_data;
    cur.keep = o_keep;
    cur.strb = o_strb;
    cur.last = o_last;
    cur.dest = o_dest;
    acc = in_v & rdy;
    if (stall_prev) begin
      chk("stall_valid_held", o_valid, 1'b1);
      chk("stall_beat_held", cur, prev_ob);
    end
    for (int i = 0; i < 3; i++) n_in += int'(acc[i]);
    n_out += int'(o_valid && net_rdy);
    stall_prev = o_valid && !net_rdy && !ap_rst;
    prev_ob = cur;
  endtask

  task automatic advance();
    @(posedge ap_clk);
    #1;
    net_rdy = ($urandom_range(99) < nr_pct);
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        if (in_b[i].last) begin
          src_npk[i]--;
          src_idx[i] = 0;
          if (src_npk[i] > 0) new_len(i);
        end else begin
          src_idx[i]++;
        end
        src_seq[i]++;
        if (hold_trig && i == 1 && src_idx[1] == 1) begin
          src_hold[1] = 3;
          hold_trig = 0;
        end
      end
      if (in_v[i] && !acc[i]) begin
        // AXI-Stream: an offered beat stays put until taken
      end else if (src_npk[i] > 0 && src_hold[i] == 0 && $urandom_range(99) < src_pv[i]) begin
        in_v[i] = 1'b1;
        in_b[i] = mk_beat(i);
      end else begin
        in_v[i] = 1'b0;
        if (src_hold[i] > 0) src_hold[i]--;
      end
    end
  endtask

  task automatic do_reset(int n, bit lit);
    ap_rst = 1'b1;
    clear_src();
    for (int k = 0; k < n; k++) begin
      sample();
      if (lit && k > 0) begin
        chk("rst_grant", arb_grant, 2'd3);
        chk("rst_busy", arb_busy, 1'b0);
        chk("rst_tvalid", o_valid, 1'b0);
        chk("rst_tready", rdy, 3'b000);
      end
      advance();
    end
    ap_rst = 1'b0;
  endtask

  task automatic wait_done(int max, string name);
    for (int k = 0; k < max && !done(); k++) begin
      sample();
      advance();
    end
    if (!done()) tmo(name);
  endtask

  int g_log[8], v_log[8], d_log[8];
  int glist[$];
  int exp_ord[6];
  int prev_g, idle_run, viol, gbad, holdc, nacc, first_g, base_in, base_out;
  bit r1_done, r2srv, started2;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_b[i] = '0;
      src_seq[i] = 0;
    end
    clear_src();
    do_reset(3, 1'b1);

    // Single requester, 4-beat packet, egress always ready
    start_src(0, 1, 4, 100);
    advance();
    for (int k = 0; k < 8; k++) begin
      sample();
      g_log[k] = int'(arb_grant);
      v_log[k] = int'(o_valid);
      d_log[k] = int'(o_data[15:0]);
      advance();
    end
    chk("p1_grant_before", g_log[0], 3);
    for (int k = 1; k <= 4; k++) chk("p1_grant_locked", g_log[k], 0);
    chk("p1_grant_release", g_log[5], 3);
    chk("p1_valid_early", v_log[1], 0);
    for (int k = 2; k <= 5; k++) begin
      chk("p1_valid_burst", v_log[k], 1);
      chk("p1_data_seq", d_log[k], k - 2);
    end
    chk("p1_valid_after", v_log[6], 0);
    wait_done(50, "p1_drain");

    // All three requesters, two 2-beat packets each, continuously valid
    do_reset(2, 1'b0);
    for (int i = 0; i < 3; i++) start_src(i, 2, 2, 100);
`ifdef NET_TX_ARB_HS_PRIORITY_EN
    exp_ord = '{2, 2, 1, 1, 0, 0};
`else
    exp_ord = '{0, 1, 2, 0, 1, 2};
`endif
    prev_g = 3;
    idle_run = 0;
    glist.delete();
    for (int k = 0; k < 100 && !done(); k++) begin
      sample();
      if (arb_grant != 2'd3 && prev_g == 3) begin
        if (glist.size() != 0) chk("p2_gap", idle_run, 1);
        glist.push_back(int'(arb_grant));
        idle_run = 0;
      end else if (arb_grant == 2'd3) begin
        idle_run++;
      end
      prev_g = int'(arb_grant);
      advance();
    end
    if (!done()) tmo("p2_drain");
    chk("p2_grant_count", glist.size(), 6);
    for (int k = 0; k < 6 && k < glist.size(); k++) chk("p2_order", glist[k], exp_ord[k]);

    // Requester 1 pauses mid-packet while requester 2 waits
    do_reset(2, 1'b0);
    start_src(1, 1, 4, 100);
    hold_trig = 1;
    started2 = 0;
    r1_done = 0;
    r2srv = 0;
    viol = 0;
    gbad = 0;
    holdc = 0;
    for (int k = 0; k < 80 && !done(); k++) begin
      sample();
      if (!started2 && arb_grant == 2'd1) begin
        start_src(2, 1, 2, 100);
        started2 = 1;
      end
      if (!r1_done && rdy[2]) viol++;
      if (!r1_done && arb_busy && arb_grant != 2'd1) gbad++;
      if (arb_busy && arb_grant == 2'd1 && !in_v[1]) holdc++;
      if (acc[1] && in_b[1].last) r1_done = 1;
      if (r1_done && rdy[2]) r2srv = 1;
      advance();
    end
    if (!done()) tmo("p3_drain");
    chk("p3_req2_started", started2, 1);
    chk("p3_req2_ready_while_locked", viol, 0);
    chk("p3_grant_kept", gbad, 0);
    chk("p3_pause_cycles", holdc, 3);
    chk("p3_req2_served_after", r2srv, 1);

    // Random traffic with 50% egress backpressure
    do_reset(2, 1'b0);
    nr_pct = 50;
    tot_beats = 0;
    base_in = n_in;
    base_out = n_out;
    for (int i = 0; i < 3; i++) start_src(i, 12, 0, 60);
    wait_done(3000, "p4_drain");
    chk("p4_beats_in", n_in - base_in, tot_beats);
    chk("p4_beats_out", n_out - base_out, tot_beats);
    nr_pct = 100;

    // Reset in the middle of a 5-beat packet
    start_src(0, 1, 5, 100);
    nacc = 0;
    for (int k = 0; k < 40 && nacc < 2; k++) begin
      sample();
      if (acc[0]) nacc++;
      advance();
    end
    chk("p5_beats_before_rst", nacc, 2);
    ap_rst = 1'b1;
    clear_src();
    sample();
    advance();
    ap_rst = 1'b0;
    sample();
    chk("p5_tvalid_after_rst", o_valid, 1'b0);
    chk("p5_grant_after_rst", arb_grant, 2'd3);
    chk("p5_busy_after_rst", arb_busy, 1'b0);
    for (int i = 0; i < 3; i++) start_src(i, 1, 1, 100);
    advance();
    first_g = 3;
    for (int k = 0; k < 10 && first_g == 3; k++) begin
      sample();
      if (arb_grant != 2'd3) first_g = int'(arb_grant);
      advance();
    end
`ifdef NET_TX_ARB_HS_PRIORITY_EN
    chk("p5_first_grant", first_g, 2);
`else
    chk("p5_first_grant", first_g, 0);
`endif
    wait_done(60, "p5_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
